cpu_sequencer: RTL

Parametrised multi-cycle control sequencer for the 16-bit CPU. It is the registered successor to the fixed fetch/execute/interrupt state and gray-coded sub-cycle encodings. It steps the core through fetch, a variable-length execute phase and an interrupt entry phase, stalling on memory handshake. It also arbitrates up to eight prioritised interrupt lines. It sits between the instruction register/decoder and the datapath control decode, which consumes `State`, `SubCycle` and `Last`.

---
 rtl/cpu_sequencer_if.sv | 32 +++
 rtl/cpu_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Handshake/control bundle between the sequencer and its surroundings.
// master: decoder/memory/interrupt side, drives MemReady, ExecCycles, IntReq, IntSet, IntClr, Reti.
// slave : sequencer, drives State, SubCycle, Last, IntAck, IntVector, IntEn, InService.
interface cpu_sequencer_if #(
  parameter int unsigned NUM_IRQ = 4
);
  localparam int unsigned VW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic               MemReady;
  logic [2:0]         ExecCycles;
  logic [NUM_IRQ-1:0] IntReq;
  logic               IntSet;
  logic               IntClr;
  logic               Reti;
  logic [1:0]         State;
  logic [2:0]         SubCycle;
  logic               Last;
  logic [NUM_IRQ-1:0] IntAck;
  logic [VW-1:0]      IntVector;
  logic               IntEn;
  logic               InService;

  modport master (
    output MemReady, ExecCycles, IntReq, IntSet, IntClr, Reti,
    input  State, SubCycle, Last, IntAck, IntVector, IntEn, InService
  );

  modport slave (
    input  MemReady, ExecCycles, IntReq, IntSet, IntClr, Reti,
    output State, SubCycle, Last, IntAck, IntVector, IntEn, InService
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch -> execute (1..MAX_CYCLES sub-cycles) -> optional
// interrupt entry (INT_CYCLES sub-cycles), stalling on MemReady, with prioritised IRQ grant.
// Ports: Clock, Reset (async active-high), bus (cpu_sequencer_if.slave).
module cpu_sequencer #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned MAX_CYCLES = 5,
  parameter int unsigned INT_CYCLES = 2
) (
  input logic             Clock,
  input logic             Reset,
  cpu_sequencer_if.slave  bus
);
  localparam int unsigned VW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [1:0]  ST_FETCH = 2'b00;
  localparam logic [1:0]  ST_EXEC  = 2'b01;
  localparam logic [1:0]  ST_INT   = 2'b10;
  localparam logic [3:0]  MAX_L    = 4'(MAX_CYCLES);
  localparam logic [2:0]  INT_LAST = 3'(INT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         sub_q, sub_d;
  logic [3:0]         len_q, len_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic [VW-1:0]      vec_q, vec_d;
  logic               en_q, en_d;
  logic               insvc_q, insvc_d;

  logic [3:0]         ec4;
  logic [3:0]         len_clamp;
  logic [VW-1:0]      gnt_idx;
  logic               last_c;

  // Sub-cycle index to the datapath's gray sequence (not the reflected code).
  function automatic logic [2:0] to_gray(input logic [2:0] i);
    case (i)
      3'd0:    to_gray = 3'b000;
      3'd1:    to_gray = 3'b001;
      3'd2:    to_gray = 3'b011;
      3'd3:    to_gray = 3'b010;
      3'd4:    to_gray = 3'b110;
      3'd5:    to_gray = 3'b100;
      3'd6:    to_gray = 3'b101;
      default: to_gray = 3'b111;
    endcase
  endfunction

  // Execute length: 0 counts as 1, long requests clamp to MAX_CYCLES.
  always_comb begin
    ec4 = {1'b0, bus.ExecCycles};
    if (ec4 == 4'd0)       len_clamp = 4'd1;
    else if (ec4 > MAX_L)  len_clamp = MAX_L;
    else                   len_clamp = ec4;
  end

  // Lowest set request index wins.
  always_comb begin
    gnt_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (bus.IntReq[i]) gnt_idx = VW'(i);
    end
  end

  // Final sub-cycle of the current state.
  always_comb begin
    case (state_q)
      ST_FETCH: last_c = 1'b1;
      ST_EXEC:  last_c = ({1'b0, idx_q} == (len_q - 4'd1));
      ST_INT:   last_c = (idx_q == INT_LAST);
      default:  last_c = 1'b1;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ack_d   = '0;
    vec_d   = vec_q;
    en_d    = en_q;
    insvc_d = insvc_q;

    if (bus.IntClr)                   en_d = 1'b0;
    else if (bus.IntSet || bus.Reti)  en_d = 1'b1;
    if (bus.Reti)                     insvc_d = 1'b0;

    if (bus.MemReady) begin
      case (state_q)
        ST_FETCH: begin
          len_d   = len_clamp;
          state_d = ST_EXEC;
          idx_d   = 3'd0;
        end
        ST_EXEC: begin
          if (last_c) begin
            idx_d = 3'd0;
            // Decision uses pre-edge enable/in-service, not this cycle's pulses.
            if (en_q && !insvc_q && (|bus.IntReq)) begin
              state_d = ST_INT;
              vec_d   = gnt_idx;
              ack_d   = NUM_IRQ'(1) << gnt_idx;
              en_d    = 1'b0;
              insvc_d = 1'b1;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        ST_INT: begin
          if (last_c) begin
            state_d = ST_FETCH;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: begin
          state_d = ST_FETCH;
          idx_d   = 3'd0;
        end
      endcase
    end

    sub_d = to_gray(idx_d);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      idx_q   <= 3'd0;
      sub_q   <= 3'b000;
      len_q   <= 4'd1;
      ack_q   <= '0;
      vec_q   <= '0;
      en_q    <= 1'b0;
      insvc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      vec_q   <= vec_d;
      en_q    <= en_d;
      insvc_q <= insvc_d;
    end
  end

  assign bus.State     = state_q;
  assign bus.SubCycle  = sub_q;
  assign bus.Last      = last_c;
  assign bus.IntAck    = ack_q;
  assign bus.IntVector = vec_q;
  assign bus.IntEn     = en_q;
  assign bus.InService = insvc_q;
endmodule
